// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI bridge: turns cache word/line read and write requests into
// single-beat or INCR bursts on an AXI master port. Reads and writes run in
// separate FSMs. A read is only accepted when the write side is idle, so a
// dirty-line write-back always sees its response before the refill read
// is issued.
module cache_axi_bridge #(
   parameter int         LINE_WORDS = 4,
   parameter logic [3:0] RD_ID      = 4'd0,
   parameter logic [3:0] WR_ID      = 4'd1
) (
   input  logic                      clk,
   input  logic                      resetn,

   // cache read port
   input  logic                      rd_req,
   input  logic [2:0]                rd_type,
   input  logic [31:0]               rd_addr,
   output logic                      rd_rdy,
   output logic                      ret_valid,
   output logic                      ret_last,
   output logic [31:0]               ret_data,

   // cache write port
   input  logic                      wr_req,
   input  logic [2:0]                wr_type,
   input  logic [31:0]               wr_addr,
   input  logic [3:0]                wr_wstrb,
   input  logic [32*LINE_WORDS-1:0]  wr_data,
   output logic                      wr_rdy,

   // AXI read address channel
   output logic [3:0]                arid,
   output logic [31:0]               araddr,
   output logic [7:0]                arlen,
   output logic [2:0]                arsize,
   output logic [1:0]                arburst,
   output logic                      arvalid,
   input  logic                      arready,

   // AXI read data channel
   input  logic [31:0]               rdata,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready,

   // AXI write address channel
   output logic [3:0]                awid,
   output logic [31:0]               awaddr,
   output logic [7:0]                awlen,
   output logic [2:0]                awsize,
   output logic [1:0]                awburst,
   output logic                      awvalid,
   input  logic                      awready,

   // AXI write data channel
   output logic [31:0]               wdata,
   output logic [3:0]                wstrb,
   output logic                      wlast,
   output logic                      wvalid,
   input  logic                      wready,

   // AXI write response channel
   input  logic                      bvalid,
   output logic                      bready
);

   localparam int         IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [7:0] LINE_LEN   = 8'(LINE_WORDS - 1);
   localparam logic [2:0] TYPE_LINE  = 3'b100;
   localparam logic [2:0] SIZE_WORD  = 3'b010;
   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ADDR,
      R_DATA
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ADDR,
      W_DATA,
      W_RESP
   } wr_state_t;

   rd_state_t rd_state;
   rd_state_t rd_state_next;
   wr_state_t wr_state;
   wr_state_t wr_state_next;

   // Cleared by reset and set on the first clock afterwards, so both ready
   // outputs stay low while reset is held even though the FSMs sit in IDLE.
   logic ready_en;

   logic [31:0]                 rd_addr_q;
   logic                        rd_line_q;
   logic [31:0]                 wr_addr_q;
   logic                        wr_line_q;
   logic [3:0]                  wr_strb_q;
   logic [LINE_WORDS-1:0][31:0] wr_data_q;
   logic [7:0]                  beat_cnt;

   logic       wr_accept;
   logic       rd_accept;
   logic [7:0] wr_len;
   logic       last_beat;

   // The ready outputs depend only on registered state, never on the requests.
   assign rd_rdy = ready_en && (rd_state == R_IDLE) && (wr_state == W_IDLE);
   assign wr_rdy = ready_en && (wr_state == W_IDLE);

   // A simultaneous write wins; the cache re-presents the read later.
   assign wr_accept = wr_req && wr_rdy;
   assign rd_accept = rd_req && rd_rdy && !wr_accept;

   assign arid    = RD_ID;
   assign araddr  = rd_addr_q;
   assign arlen   = rd_line_q ? LINE_LEN : 8'd0;
   assign arsize  = SIZE_WORD;
   assign arburst = BURST_INCR;

   assign wr_len    = wr_line_q ? LINE_LEN : 8'd0;
   assign last_beat = (beat_cnt == wr_len);

   assign awid    = WR_ID;
   assign awaddr  = wr_addr_q;
   assign awlen   = wr_len;
   assign awsize  = SIZE_WORD;
   assign awburst = BURST_INCR;

   // State registers for both FSMs plus the post-reset ready enable.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_state <= R_IDLE;
         wr_state <= W_IDLE;
         ready_en <= 1'b0;
      end else begin
         rd_state <= rd_state_next;
         wr_state <= wr_state_next;
         ready_en <= 1'b1;
      end
   end

   // Capture the read request so the AR fields hold steady until arready.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_addr_q <= 32'h0;
         rd_line_q <= 1'b0;
      end else if (rd_accept) begin
         rd_addr_q <= rd_addr;
         rd_line_q <= (rd_type == TYPE_LINE);
      end
   end

   // Capture the whole write request, including every word of the line.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_addr_q <= 32'h0;
         wr_line_q <= 1'b0;
         wr_strb_q <= 4'h0;
         wr_data_q <= '0;
      end else if (wr_accept) begin
         wr_addr_q <= wr_addr;
         wr_line_q <= (wr_type == TYPE_LINE);
         wr_strb_q <= wr_wstrb;
         wr_data_q <= wr_data;
      end
   end

   // Beat counter: restarts when the address is taken, steps on each W handshake.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beat_cnt <= 8'd0;
      end else if ((wr_state == W_ADDR) && awready) begin
         beat_cnt <= 8'd0;
      end else if ((wr_state == W_DATA) && wready) begin
         beat_cnt <= beat_cnt + 8'd1;
      end
   end

   // Read FSM: next state, AR valid and the zero-latency return path.
   always_comb begin
      rd_state_next = rd_state;
      arvalid       = 1'b0;
      rready        = 1'b0;
      ret_valid     = 1'b0;
      ret_last      = 1'b0;
      ret_data      = 32'h0;
      case (rd_state)
         R_IDLE: begin
            if (rd_accept) begin
               rd_state_next = R_ADDR;
            end
         end
         R_ADDR: begin
            arvalid = 1'b1;
            if (arready) begin
               rd_state_next = R_DATA;
            end
         end
         R_DATA: begin
            rready    = 1'b1;
            ret_valid = rvalid;
            ret_last  = rvalid && rlast;
            ret_data  = rdata;
            if (rvalid && rlast) begin
               rd_state_next = R_IDLE;
            end
         end
         default: begin
            rd_state_next = R_IDLE;
         end
      endcase
   end

   // Write FSM: next state plus AW/W/B channel handshake outputs.
   always_comb begin
      wr_state_next = wr_state;
      awvalid       = 1'b0;
      wvalid        = 1'b0;
      wlast         = 1'b0;
      wdata         = 32'h0;
      wstrb         = 4'h0;
      bready        = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (wr_accept) begin
               wr_state_next = W_ADDR;
            end
         end
         W_ADDR: begin
            awvalid = 1'b1;
            if (awready) begin
               wr_state_next = W_DATA;
            end
         end
         W_DATA: begin
            wvalid = 1'b1;
            wdata  = wr_data_q[beat_cnt[IDX_W-1:0]];
            wstrb  = wr_line_q ? 4'hf : wr_strb_q;
            wlast  = last_beat;
            if (wready && last_beat) begin
               wr_state_next = W_RESP;
            end
         end
         W_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               wr_state_next = W_IDLE;
            end
         end
         default: begin
            wr_state_next = W_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge. The bench plays the AXI slave.
// Expected read-return beats and write beats go into scoreboard queues when
// the stimulus is driven, and they are popped and compared as the DUT produces them.
module tb_cache_axi_bridge;

   localparam int LINE_WORDS = 4;

   logic                     clk = 1'b0;
   logic                     resetn;
   logic                     rd_req;
   logic [2:0]               rd_type;
   logic [31:0]              rd_addr;
   logic                     rd_rdy;
   logic                     ret_valid;
   logic                     ret_last;
   logic [31:0]              ret_data;
   logic                     wr_req;
   logic [2:0]               wr_type;
   logic [31:0]              wr_addr;
   logic [3:0]               wr_wstrb;
   logic [32*LINE_WORDS-1:0] wr_data;
   logic                     wr_rdy;
   logic [3:0]               arid;
   logic [31:0]              araddr;
   logic [7:0]               arlen;
   logic [2:0]               arsize;
   logic [1:0]               arburst;
   logic                     arvalid;
   logic                     arready;
   logic [31:0]              rdata;
   logic                     rlast;
   logic                     rvalid;
   logic                     rready;
   logic [3:0]               awid;
   logic [31:0]              awaddr;
   logic [7:0]               awlen;
   logic [2:0]               awsize;
   logic [1:0]               awburst;
   logic                     awvalid;
   logic                     awready;
   logic [31:0]              wdata;
   logic [3:0]               wstrb;
   logic                     wlast;
   logic                     wvalid;
   logic                     wready;
   logic                     bvalid;
   logic                     bready;

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_r[$];
   logic [36:0] exp_w[$];

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   cache_axi_bridge #(
      .LINE_WORDS (LINE_WORDS),
      .RD_ID      (4'd0),
      .WR_ID      (4'd1)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rd_req    (rd_req),
      .rd_type   (rd_type),
      .rd_addr   (rd_addr),
      .rd_rdy    (rd_rdy),
      .ret_valid (ret_valid),
      .ret_last  (ret_last),
      .ret_data  (ret_data),
      .wr_req    (wr_req),
      .wr_type   (wr_type),
      .wr_addr   (wr_addr),
      .wr_wstrb  (wr_wstrb),
      .wr_data   (wr_data),
      .wr_rdy    (wr_rdy),
      .arid      (arid),
      .araddr    (araddr),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .rready    (rready),
      .awid      (awid),
      .awaddr    (awaddr),
      .awlen     (awlen),
      .awsize    (awsize),
      .awburst   (awburst),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wlast     (wlast),
      .wvalid    (wvalid),
      .wready    (wready),
      .bvalid    (bvalid),
      .bready    (bready)
   );

   // AXI read slave: hold AR for ar_delay cycles, then send n_send of n_beats beats.
   // Junk on R during the address phase must be ignored by the bridge.
   task automatic serve_read(input logic [31:0] exp_addr, input logic [7:0] exp_len,
                             input int ar_delay, input int n_beats, input int n_send,
                             input logic [31:0] base, input bit gap);
      int          pulses;
      logic [32:0] exp;
      logic [32:0] got;
      pulses = 0;
      for (int d = 0; d <= ar_delay; d++) begin
         arready = (d == ar_delay);
         rvalid  = 1'b1;
         rdata   = 32'hDEAD_BEEF;
         rlast   = 1'b1;
         #1;
         checks++;
         if (arvalid !== 1'b1 || araddr !== exp_addr || arlen !== exp_len ||
             arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'd0) begin
            errors++;
            $display("[TB] FAIL ar_channel: got valid=%b addr=%h len=%0d size=%b burst=%b id=%h, expected 1 %h %0d 010 01 0",
                     arvalid, araddr, arlen, arsize, arburst, arid, exp_addr, exp_len);
         end
         checks++;
         if (rready !== 1'b0 || ret_valid !== 1'b0 || ret_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL r_ignored: got rready=%b ret_valid=%b ret_last=%b, expected 0 0 0",
                     rready, ret_valid, ret_last);
         end
         @(negedge clk);
      end
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      for (int i = 0; i < n_send; i++) begin
         rvalid = 1'b1;
         rdata  = base + 32'(i);
         rlast  = (i == n_beats - 1);
         exp_r.push_back({rlast, rdata});
         #1;
         checks++;
         if (rready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rready: got %b, expected 1", rready);
         end
         if (ret_valid === 1'b1) begin
            pulses++;
            checks++;
            exp = exp_r.pop_front();
            got = {ret_last, ret_data};
            if (got !== exp) begin
               errors++;
               $display("[TB] FAIL ret_beat %0d: got last=%b data=%h, expected last=%b data=%h",
                        i, got[32], got[31:0], exp[32], exp[31:0]);
            end
         end
         @(negedge clk);
         rvalid = 1'b0;
         if (gap && (i != n_beats - 1)) begin
            rlast = 1'b1;
            rdata = 32'hBAD0_0000;
            #1;
            checks++;
            if (ret_valid !== 1'b0 || ret_last !== 1'b0 || rready !== 1'b1) begin
               errors++;
               $display("[TB] FAIL r_gap: got ret_valid=%b ret_last=%b rready=%b, expected 0 0 1",
                        ret_valid, ret_last, rready);
            end
            @(negedge clk);
            rlast = 1'b0;
         end
      end
      rlast = 1'b0;
      checks++;
      if (pulses != n_send || exp_r.size() != 0) begin
         errors++;
         $display("[TB] FAIL ret_count: got %0d pulses (%0d unmatched), expected %0d",
                  pulses, exp_r.size(), n_send);
      end
      exp_r.delete();
   endtask

   // AXI write slave: AW after aw_delay cycles, W beats checked against the
   // scoreboard (wready toggles when asked), then one idle cycle and bvalid.
   task automatic serve_write(input logic [31:0] exp_addr, input logic [7:0] exp_len,
                              input int aw_delay, input bit toggle);
      int          beats;
      int          hs;
      int          cyc;
      logic [36:0] exp;
      logic [36:0] got;
      beats = int'(exp_len) + 1;
      for (int d = 0; d <= aw_delay; d++) begin
         awready = (d == aw_delay);
         #1;
         checks++;
         if (awvalid !== 1'b1 || awaddr !== exp_addr || awlen !== exp_len ||
             awsize !== 3'b010 || awburst !== 2'b01 || awid !== 4'd1) begin
            errors++;
            $display("[TB] FAIL aw_channel: got valid=%b addr=%h len=%0d size=%b burst=%b id=%h, expected 1 %h %0d 010 01 1",
                     awvalid, awaddr, awlen, awsize, awburst, awid, exp_addr, exp_len);
         end
         checks++;
         if (wvalid !== 1'b0 || wr_rdy !== 1'b0 || rd_rdy !== 1'b0 || arvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL aw_side: got wvalid=%b wr_rdy=%b rd_rdy=%b arvalid=%b, expected all 0",
                     wvalid, wr_rdy, rd_rdy, arvalid);
         end
         @(negedge clk);
      end
      awready = 1'b0;
      hs  = 0;
      cyc = 0;
      while (hs < beats && cyc < 64) begin
         wready = toggle ? ((cyc % 2) == 0) : 1'b1;
         #1;
         exp = (exp_w.size() != 0) ? exp_w[0] : 37'h0;
         got = {wlast, wstrb, wdata};
         checks++;
         if (wvalid !== 1'b1 || got !== exp) begin
            errors++;
            $display("[TB] FAIL w_beat %0d (wready=%b): got valid=%b last=%b strb=%b data=%h, expected 1 %b %b %h",
                     hs, wready, wvalid, got[36], got[35:32], got[31:0], exp[36], exp[35:32], exp[31:0]);
         end
         checks++;
         if (rd_rdy !== 1'b0 || arvalid !== 1'b0 || wr_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL w_side: got rd_rdy=%b arvalid=%b wr_rdy=%b, expected 0 0 0",
                     rd_rdy, arvalid, wr_rdy);
         end
         if (wready) begin
            hs++;
            if (exp_w.size() != 0) exp = exp_w.pop_front();
         end
         @(negedge clk);
         cyc++;
      end
      wready = 1'b0;
      #1;
      checks++;
      if (wvalid !== 1'b0 || bready !== 1'b1 || wr_rdy !== 1'b0 || rd_rdy !== 1'b0 ||
          arvalid !== 1'b0 || exp_w.size() != 0) begin
         errors++;
         $display("[TB] FAIL b_wait: got wvalid=%b bready=%b wr_rdy=%b rd_rdy=%b arvalid=%b left=%0d, expected 0 1 0 0 0 0",
                  wvalid, bready, wr_rdy, rd_rdy, arvalid, exp_w.size());
      end
      exp_w.delete();
      @(negedge clk);
      bvalid = 1'b1;
      #1;
      checks++;
      if (bready !== 1'b1 || wr_rdy !== 1'b0 || arvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b_cycle: got bready=%b wr_rdy=%b arvalid=%b, expected 1 0 0",
                  bready, wr_rdy, arvalid);
      end
      @(negedge clk);
      bvalid = 1'b0;
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      rd_req   = 1'b0;
      rd_type  = 3'b000;
      rd_addr  = 32'h0;
      wr_req   = 1'b0;
      wr_type  = 3'b000;
      wr_addr  = 32'h0;
      wr_wstrb = 4'h0;
      wr_data  = '0;
      arready  = 1'b0;
      rdata    = 32'h0;
      rlast    = 1'b0;
      rvalid   = 1'b0;
      awready  = 1'b0;
      wready   = 1'b0;
      bvalid   = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({arvalid, awvalid, wvalid, wlast, rready, bready, ret_valid, ret_last, rd_rdy, wr_rdy} !== 10'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b, expected 0000000000",
                  {arvalid, awvalid, wvalid, wlast, rready, bready, ret_valid, ret_last, rd_rdy, wr_rdy});
      end
      checks++;
      if (araddr !== 32'h0 || awaddr !== 32'h0 || arlen !== 8'd0 || awlen !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_fields: got araddr=%h awaddr=%h arlen=%0d awlen=%0d, expected 0 0 0 0",
                  araddr, awaddr, arlen, awlen);
      end
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release: got rd_rdy=%b wr_rdy=%b, expected 1 1", rd_rdy, wr_rdy);
      end
   endtask

   task automatic test_line_read();
      rd_req  = 1'b1;
      rd_type = 3'b100;
      rd_addr = 32'h1C00_0040;
      #1;
      checks++;
      if (rd_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL line_read_rdy: got %b, expected 1", rd_rdy);
      end
      @(negedge clk);
      rd_req  = 1'b0;
      rd_type = 3'b000;
      rd_addr = 32'h0;
      serve_read(32'h1C00_0040, 8'd3, 2, 4, 4, 32'hA0, 1'b1);
      #1;
      checks++;
      if (rd_rdy !== 1'b1 || rready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL line_read_done: got rd_rdy=%b rready=%b, expected 1 0", rd_rdy, rready);
      end
      @(negedge clk);
   endtask

   task automatic test_word_write();
      wr_req   = 1'b1;
      wr_type  = 3'b010;
      wr_addr  = 32'hBFAF_8000;
      wr_wstrb = 4'b0011;
      wr_data  = {32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD_DDDD, 32'h1234_5678};
      exp_w.push_back({1'b1, 4'b0011, 32'h1234_5678});
      #1;
      checks++;
      if (wr_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL word_write_rdy: got %b, expected 1", wr_rdy);
      end
      @(negedge clk);
      wr_req   = 1'b0;
      wr_addr  = 32'h0;
      wr_wstrb = 4'h0;
      wr_data  = '0;
      serve_write(32'hBFAF_8000, 8'd0, 0, 1'b0);
      #1;
      checks++;
      if (wr_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL word_write_done: got wr_rdy=%b, expected 1", wr_rdy);
      end
      @(negedge clk);
   endtask

   task automatic test_writeback_refill();
      wr_req   = 1'b1;
      wr_type  = 3'b100;
      wr_addr  = 32'h0000_0100;
      wr_wstrb = 4'h0;
      wr_data  = {32'h44, 32'h33, 32'h22, 32'h11};
      rd_req   = 1'b1;
      rd_type  = 3'b100;
      rd_addr  = 32'h0000_0200;
      exp_w.push_back({1'b0, 4'hf, 32'h11});
      exp_w.push_back({1'b0, 4'hf, 32'h22});
      exp_w.push_back({1'b0, 4'hf, 32'h33});
      exp_w.push_back({1'b1, 4'hf, 32'h44});
      #1;
      checks++;
      if (wr_rdy !== 1'b1 || rd_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wb_both_rdy: got wr_rdy=%b rd_rdy=%b, expected 1 1", wr_rdy, rd_rdy);
      end
      @(negedge clk);
      wr_req  = 1'b0;
      wr_type = 3'b000;
      wr_addr = 32'h0;
      wr_data = '0;
      serve_write(32'h0000_0100, 8'd3, 1, 1'b0);
      #1;
      checks++;
      if (arvalid !== 1'b0 || rd_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ar_after_b: got arvalid=%b rd_rdy=%b, expected 0 1", arvalid, rd_rdy);
      end
      @(negedge clk);
      rd_req  = 1'b0;
      rd_type = 3'b000;
      rd_addr = 32'h0;
      serve_read(32'h0000_0200, 8'd3, 0, 4, 4, 32'hC0, 1'b0);
      #1;
      checks++;
      if (rd_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL refill_done: got rd_rdy=%b, expected 1", rd_rdy);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      wr_req   = 1'b1;
      wr_type  = 3'b100;
      wr_addr  = 32'h0000_0080;
      wr_wstrb = 4'b0101;
      wr_data  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
      for (int i = 0; i < 4; i++) begin
         exp_w.push_back({(i == 3), 4'hf, 32'hB0 + 32'(i)});
      end
      #1;
      checks++;
      if (wr_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_rdy: got %b, expected 1", wr_rdy);
      end
      @(negedge clk);
      wr_req   = 1'b0;
      wr_wstrb = 4'h0;
      wr_data  = '0;
      serve_write(32'h0000_0080, 8'd3, 1, 1'b1);
      #1;
      checks++;
      if (wr_rdy !== 1'b1 || wvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_done: got wr_rdy=%b wvalid=%b, expected 1 0", wr_rdy, wvalid);
      end
      @(negedge clk);
   endtask

   task automatic test_odd_types();
      wr_req   = 1'b1;
      wr_type  = 3'b001;
      wr_addr  = 32'h0000_0040;
      wr_wstrb = 4'b1000;
      wr_data  = {32'h0, 32'h0, 32'h9999_9999, 32'hCAFE_F00D};
      exp_w.push_back({1'b1, 4'b1000, 32'hCAFE_F00D});
      @(negedge clk);
      wr_req   = 1'b0;
      wr_wstrb = 4'h0;
      wr_data  = '0;
      serve_write(32'h0000_0040, 8'd0, 0, 1'b0);
      rd_req  = 1'b1;
      rd_type = 3'b000;
      rd_addr = 32'h0000_0044;
      #1;
      checks++;
      if (rd_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL odd_read_rdy: got %b, expected 1", rd_rdy);
      end
      @(negedge clk);
      rd_req  = 1'b0;
      rd_addr = 32'h0;
      serve_read(32'h0000_0044, 8'd0, 1, 1, 1, 32'h77, 1'b0);
   endtask

   task automatic test_reset_mid_read();
      rd_req  = 1'b1;
      rd_type = 3'b100;
      rd_addr = 32'h0000_3000;
      @(negedge clk);
      rd_req  = 1'b0;
      rd_type = 3'b000;
      rd_addr = 32'h0;
      serve_read(32'h0000_3000, 8'd3, 0, 4, 2, 32'hD0, 1'b0);
      resetn = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'hD2;
      rlast  = 1'b0;
      #1;
      checks++;
      if ({arvalid, awvalid, wvalid, wlast, rready, bready, ret_valid, ret_last, rd_rdy, wr_rdy} !== 10'b0 ||
          araddr !== 32'h0 || arlen !== 8'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset_outputs: got flags=%b araddr=%h arlen=%0d, expected 0 0 0",
                  {arvalid, awvalid, wvalid, wlast, rready, bready, ret_valid, ret_last, rd_rdy, wr_rdy},
                  araddr, arlen);
      end
      @(negedge clk);
      rvalid = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1 || ret_valid !== 1'b0 || rready !== 1'b0 || arvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_idle: got rd_rdy=%b wr_rdy=%b ret_valid=%b rready=%b arvalid=%b, expected 1 1 0 0 0",
                  rd_rdy, wr_rdy, ret_valid, rready, arvalid);
      end
      rd_req  = 1'b1;
      rd_type = 3'b010;
      rd_addr = 32'h0000_0048;
      @(negedge clk);
      rd_req  = 1'b0;
      rd_type = 3'b000;
      rd_addr = 32'h0;
      serve_read(32'h0000_0048, 8'd0, 0, 1, 1, 32'h55, 1'b0);
      #1;
      checks++;
      if (rd_rdy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL post_reset_read: got rd_rdy=%b, expected 1", rd_rdy);
      end
      @(negedge clk);
   endtask

   // Main sequence of scenarios.
   initial begin
      $display("[TB] starting cache_axi_bridge bench");
      test_reset();
      test_line_read();
      test_word_write();
      test_writeback_refill();
      test_backpressure();
      test_odd_types();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, giving the 32-bit words per cache line (cache line burst length).
REQ-002 SHALL have parameter RD_ID, default 4'd0, giving the constant arid.
REQ-003 SHALL have parameter WR_ID, default 4'd1, giving the constant awid.
REQ-004 SHALL have ports:
- clk  in  1  the single clock.
- resetn  in  1  asynchronous, active-low reset.
- rd_req  in  1  cache read request.
- rd_type  in  3  read type: 010 word, 100 line.
- rd_addr  in  32  read byte address.
- rd_rdy  out  1  bridge can accept a read.
- ret_valid  out  1  read data beat valid.
- ret_last  out  1  final read beat.
- ret_data  out  32  read data beat.
- wr_req  in  1  cache write request.
- wr_type  in  3  write type: 010 word, 100 line.
- wr_addr  in  32  write byte address.
- wr_wstrb  in  4  byte strobes, used only for word writes.
- wr_data  in  32*LINE_WORDS  write data; word 0 is in bits [31:0].
- wr_rdy  out  1  bridge can accept a write.
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI read address channel.
- arready  in  1  AXI read address ready.
- rdata/rlast/rvalid  in  32/1/1  AXI read data channel.
- rready  out  1  AXI read data ready.
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI write address channel.
- awready  in  1  AXI write address ready.
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data channel.
- wready  in  1  AXI write data ready.
- bvalid  in  1  AXI write response valid.
- bready  out  1  AXI write response ready.

Function
REQ-005 SHALL run independent read and write FSMs.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
REQ-006 rd_rdy and wr_rdy SHALL be driven from registered state only, never from rd_req/wr_req, because the cache gates its requests with these signals combinationally.
REQ-007 wr_rdy SHALL be 1 only in W_IDLE.
REQ-008 rd_rdy SHALL be 1 only when the read FSM is in R_IDLE and the write FSM is in W_IDLE. A dirty-line write-back therefore always receives its bvalid before the refill read is issued.
REQ-009 On rd_req&&rd_rdy the bridge SHALL latch the address and type, then go R_IDLE->R_ADDR with arvalid=1 from the next cycle.
REQ-010 AR fields:
- araddr = latched rd_addr.
- arsize = 3'b010, arburst = 2'b01.
- arlen = LINE_WORDS-1 for type 100, otherwise 0.
REQ-011 arvalid and all ar* fields SHALL stay stable until arready. On arready the FSM goes R_ADDR->R_DATA.
REQ-012 In R_DATA:
- rready = 1.
- ret_valid = rvalid, ret_data = rdata, ret_last = rvalid&&rlast, all combinational with zero added latency.
- rvalid&&rlast returns the FSM to R_IDLE.
REQ-013 Outside R_DATA, rready, ret_valid and ret_last SHALL be 0, and the bridge SHALL ignore rvalid.
REQ-014 On wr_req&&wr_rdy the bridge SHALL latch address, type, strobe and full line data, then go to W_ADDR with awvalid=1.
REQ-015 AW fields:
- awaddr = latched address.
- awsize = 3'b010, awburst = 2'b01.
- awlen = LINE_WORDS-1 for a line, 0 for a word.
REQ-016 On awready the FSM SHALL go to W_DATA with a beat counter set to 0.
REQ-017 In W_DATA:
- wvalid = 1.
- wdata = latched word[counter].
- wstrb = 4'hf for a line, latched wr_wstrb for a word.
- wlast = 1 when counter == awlen.
REQ-018 Each wready SHALL increment the counter. wready&&wlast SHALL go to W_RESP.
REQ-019 In W_RESP, bready SHALL be 1, and bvalid SHALL return the FSM to W_IDLE.
REQ-020 Beats, addresses and IDs SHALL never change while their valid is high and ready is low.
REQ-021 rd_req and wr_req asserted in the same cycle with both FSMs idle: only the write SHALL be accepted, since rd_rdy is 1 but the read is re-presented by the cache after the write completes. The bridge SHALL NOT latch the read while wr_req&&wr_rdy is accepted that cycle.
REQ-022 Requests of type 000/001 SHALL be treated as word type (len 0) with arsize/awsize = 3'b010.

Reset
REQ-023 While resetn=0, asynchronously:
- both FSMs go to IDLE.
- arvalid, awvalid, wvalid, wlast, rready, bready, ret_valid and ret_last are 0.
- rd_rdy and wr_rdy are 0.
- the counter and all latched fields are 0.
REQ-024 Reset asserted mid-burst SHALL abandon the transaction. On the first clk after deassertion rd_rdy = wr_rdy = 1, with no residual beats.

Verification
REQ-025 Line read: rd_req with type 100 at 0x1C000040, arready delayed 2 cycles, 4 rvalid beats 0xA0..0xA3 with a 1-cycle gap -> arlen=3 with araddr stable, 4 ret_valid pulses, ret_last only on 0xA3, rd_rdy=1 the next cycle.
REQ-026 Uncached word write: type 010 to 0xBFAF8000, data 0x12345678, wstrb 4'b0011 -> awlen=0 and a single beat with wlast=1, wstrb=0011; wr_rdy=0 until bvalid, then 1.
REQ-027 Dirty write-back then refill: line write of 0x11,0x22,0x33,0x44 to 0x100, read of 0x200 requested concurrently -> all 4 W beats in order, ar issued only after the bvalid cycle.
REQ-028 Backpressure: wready toggling 1,0,1,0 -> every beat is held stable while wready=0, wlast is on the 4th beat only, and there are exactly 4 handshakes.
REQ-029 Reset mid-read after 2 of 4 beats -> all outputs 0 during reset, idle afterwards, and a new read works normally.
